jk_excitation_driver: RTL

// - Drive side of the JK flip-flop interface: converts a stream of target register values into per-bit J/K

---
 rtl/jk_drv_pkg.sv | 30 +++
 rtl/jk_excite.sv | 23 ++
 rtl/jk_excitation_driver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/jk_drv_pkg.sv
// Shared types and the per-bit JK excitation table for the JK excitation driver.
// Pure declarations: no latency or backpressure of its own.
package jk_drv_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    DRIVE  = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4
  } state_t;

  localparam int DC_HOLD   = 0;
  localparam int DC_TOGGLE = 1;

  localparam int ERR_CNT_W = 8;

  // Returns {j, k} moving one flip-flop from q to target. Don't-care inputs are
  // filled with 0 (hold-preferring) or with 1 (toggle-preferring).
  function automatic logic [1:0] excite_bit(input logic q, input logic t, input logic dc_toggle);
    logic [1:0] jk;
    case ({q, t})
      2'b01:   jk = dc_toggle ? 2'b11 : 2'b10;
      2'b10:   jk = dc_toggle ? 2'b11 : 2'b01;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational WIDTH-wide J/K excitation from current q and target value.
// Zero latency; no handshake.
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] target,
  input  logic             dc_mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = excite_bit(q[i], target[i], dc_mode);
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Handshaked J/K sequencer for a WIDTH-bit JK bank, confirming each transfer via q feedback with bounded retry.
// Accept to done is 3+SETTLE_CYCLES cycles, plus 2+SETTLE_CYCLES per retry; in_ready is low while a transfer is in flight.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int DC_MODE       = DC_HOLD,
  parameter int MAX_RETRY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     q_fb,
  output logic [WIDTH-1:0]     jk_j,
  output logic [WIDTH-1:0]     jk_k,
  output logic                 ff_rst,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int          SCW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [2:0]  RETRY_MAX  = 3'(MAX_RETRY);
  localparam logic        DC_TOGGLES = (DC_MODE == DC_TOGGLE);

  state_t                 state;
  state_t                 state_nxt;
  logic [WIDTH-1:0]       target_q;
  logic [SCW-1:0]         settle_cnt;
  logic [2:0]             retry_cnt;

  logic [WIDTH-1:0]       drive_target;
  logic [WIDTH-1:0]       exc_j;
  logic [WIDTH-1:0]       exc_k;
  logic [WIDTH-1:0]       diff_now;
  logic                   pass;
  logic                   exhausted;

  logic [WIDTH-1:0]       jk_j_nxt;
  logic [WIDTH-1:0]       jk_k_nxt;
  logic                   done_nxt;
  logic                   err_nxt;

  assign in_ready  = (state == IDLE);
  assign diff_now  = q_fb ^ target_q;
  assign pass      = (diff_now == '0);
  assign exhausted = (retry_cnt >= RETRY_MAX);

  // J/K are registered so they are valid throughout DRIVE. The bank holds while
  // J=K=0 (IDLE, CHECK), so q_fb one cycle ahead equals q_fb during DRIVE.
  assign drive_target = (state == IDLE) ? in_data : target_q;

  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .q       (q_fb),
    .target  (drive_target),
    .dc_mode (DC_TOGGLES),
    .j       (exc_j),
    .k       (exc_k)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = IDLE;
      IDLE:    if (in_valid) state_nxt = DRIVE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = CHECK;
      CHECK:   state_nxt = (!pass && !exhausted) ? DRIVE : IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    jk_j_nxt = '0;
    jk_k_nxt = '0;
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (state_nxt == DRIVE) begin
      jk_j_nxt = exc_j;
      jk_k_nxt = exc_k;
    end
    if (state == CHECK && (pass || exhausted)) begin
      done_nxt = 1'b1;
      err_nxt  = !pass;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q   <= '0;
      settle_cnt <= '0;
      retry_cnt  <= '0;
      jk_j       <= '0;
      jk_k       <= '0;
      ff_rst     <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      mismatch   <= '0;
      err_cnt    <= '0;
    end else begin
      jk_j   <= jk_j_nxt;
      jk_k   <= jk_k_nxt;
      ff_rst <= (state_nxt == INIT);
      done   <= done_nxt;
      err    <= err_nxt;

      if (state == IDLE && in_valid) begin
        target_q <= in_data;
      end

      if (state == DRIVE) begin
        settle_cnt <= SCW'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end

      if (state == CHECK) begin
        mismatch <= diff_now;
        if (pass || exhausted) begin
          retry_cnt <= '0;
        end else begin
          retry_cnt <= retry_cnt + 3'd1;
        end
      end

      // Saturating count of transfers that ran out of retries.
      if (err_nxt && err_cnt != {ERR_CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
